instruction_fetch: RTL

- Requestor-side master that sits directly upstream of the three-port memory arbiter, on one device slot (instruction port).
- Issues read requests, with burst hint, for sequential instruction words.
- Captures returned words into a small prefetch FIFO and hands {pc, instr} pairs to the instruction decoder over a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and discarding in-flight returns.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instruction_fetch_if.sv | 35 +++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instruction_fetch.sv | 109 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch slice.
package fetch_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Arbiter-side memory port plus decoder-side instruction stream of the fetch unit.
interface instruction_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_en;
   logic              mem_burst_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_di;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_do;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output mem_en, mem_burst_en, mem_we, mem_addr, mem_di,
      input  mem_ack, mem_do,
      input  redirect_valid, redirect_pc,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_en, mem_burst_en, mem_we, mem_addr, mem_di,
      output mem_ack, mem_do,
      output redirect_valid, redirect_pc,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: push/pop/flush with a combinational head; flush beats push and pop.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != DEPTH_C);
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch master: sequential word reads into a prefetch FIFO, with
// branch redirect flushing the FIFO and discarding the return that is in flight.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int              ADDR_W     = ADDR_W_DEF,
   parameter int              DATA_W     = DATA_W_DEF,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 reset,
   instruction_fetch_if.master bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
   localparam logic [CNT_W-1:0] THREE   = CNT_W'(3);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  free;
   logic [CNT_W-1:0]  free_next;
   logic [ENT_W-1:0]  head;
   logic              ack_ok;
   logic              push;
   logic              pop;

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect_valid),
      .din   ({req_pc, bus.mem_do}),
      .head  (head),
      .count (count)
   );

   // Acks in DRAIN or alongside a redirect belong to the abandoned stream.
   // A full-FIFO ack is a protocol violation and is dropped without advancing.
   always_comb begin
      ack_ok     = bus.mem_ack && (state != DRAIN) && !bus.redirect_valid;
      push       = ack_ok && (count != DEPTH_C);
      pop        = (count != '0) && bus.instr_ready && !bus.redirect_valid;
      count_next = count + CNT_W'(push) - CNT_W'(pop);
      free       = DEPTH_C - count;
      free_next  = DEPTH_C - count_next;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Requests only start with two free slots so a single late ack always fits.
   always_comb begin
      state_next = state;
      if (bus.redirect_valid) begin
         state_next = DRAIN;
      end else begin
         case (state)
            IDLE:    if (free_next >= TWO) state_next = FETCH;
            FETCH:   if (free_next < TWO)  state_next = IDLE;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.mem_en       = 1'b0;
      bus.mem_burst_en = 1'b0;
      bus.mem_addr     = '0;
      if (state == FETCH) begin
         bus.mem_en       = 1'b1;
         bus.mem_burst_en = (free >= THREE);
         bus.mem_addr     = fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else if (bus.redirect_valid) begin
         fetch_pc <= bus.redirect_pc;
         req_pc   <= bus.redirect_pc;
      end else if (push) begin
         fetch_pc <= fetch_pc + 1'b1;
         req_pc   <= req_pc + 1'b1;
      end
   end

   assign bus.mem_we      = 1'b0;
   assign bus.mem_di      = '0;
   assign bus.instr_valid = (count != '0);
   assign bus.instr_pc    = head[ENT_W-1 -: ADDR_W];
   assign bus.instr       = head[DATA_W-1:0];
endmodule
